// File: rtl/spi_master_ctrl_if.sv
// CPU register port and SPI pin bundle for spi_master_ctrl.
interface spi_master_ctrl_if #(
    parameter int W_CPU = 32,
    parameter int N_CS  = 4
);
    logic             wr_en;
    logic             rd_en;
    logic [1:0]       addr;
    logic [W_CPU-1:0] wd;
    logic [W_CPU-1:0] rd_data;
    logic             sclk;
    logic             mosi;
    logic             miso;
    logic [N_CS-1:0]  cs_n;

    // CPU / pad side of the bundle
    modport master (output wr_en, rd_en, addr, wd, miso,
                    input  rd_data, sclk, mosi, cs_n);
    // controller side of the bundle
    modport slave  (input  wr_en, rd_en, addr, wd, miso,
                    output rd_data, sclk, mosi, cs_n);
endinterface

// File: rtl/spi_master_ctrl.sv
// CPU-mapped SPI master: CTRL/STATUS/TXDATA/RXDATA registers, TX and RX
// FIFOs, programmable half-period, CPOL/CPHA modes and decoded chip selects.
module spi_master_ctrl #(
    parameter int W_CPU      = 32,
    parameter int W_FRAME    = 8,
    parameter int N_CS       = 4,
    parameter int FIFO_DEPTH = 4,
    parameter int W_DIV      = 8
) (
    input  logic             clk,
    input  logic             rst,
    spi_master_ctrl_if.slave bus
);
    localparam int CS_W = (N_CS > 1) ? $clog2(N_CS) : 1;
    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int HW   = $clog2(2 * W_FRAME);
    localparam logic [HW-1:0] HALF_LAST = HW'(2 * W_FRAME - 1);
    localparam logic [AW:0]   CNT_FULL  = (AW + 1)'(FIFO_DEPTH);
    localparam logic [1:0] A_CTRL = 2'd0, A_STATUS = 2'd1, A_TX = 2'd2, A_RX = 2'd3;

    typedef enum logic [1:0] {IDLE, LEAD, SHIFT, TRAIL} state_t;

    state_t             state;
    logic               ctl_en, ctl_cpha, ctl_cpol;
    logic [W_DIV-1:0]   ctl_div;
    logic [CS_W-1:0]    ctl_cs;
    logic               cpha_l, cpol_l;
    logic [W_DIV-1:0]   div_l, cnt;
    logic [HW-1:0]      half;
    logic               chain;
    logic [W_FRAME-1:0] tx_sr, rx_sr;
    logic               tx_ovf, rx_ovf;
    logic               sclk_reg, mosi_reg;
    logic [N_CS-1:0]    cs_n_reg;
    logic [W_CPU-1:0]   rd_data_reg;
    logic [W_FRAME-1:0] tx_mem [FIFO_DEPTH];
    logic [W_FRAME-1:0] rx_mem [FIFO_DEPTH];
    logic [AW-1:0]      tx_wp, tx_rp, rx_wp, rx_rp;
    logic [AW:0]        tx_cnt, rx_cnt;

    logic tx_full, tx_empty, rx_full, rx_empty, busy;
    logic h_done, last_half, edge_now, edge_lead, do_sample, load_cpha;
    logic tx_pop, tx_push, tx_ovf_set, rx_push_ev, rx_push, rx_pop, rx_ovf_set, stat_rd;
    logic [W_FRAME-1:0] frame;
    logic [W_CPU-1:0]   rd_mux;

    // one-hot active-low select; out-of-range selects leave every line high
    function automatic logic [N_CS-1:0] cs_decode(input logic [CS_W-1:0] sel);
        logic [N_CS-1:0] v;
        for (int i = 0; i < N_CS; i++) begin
            if (int'(sel) == i) v[i] = 1'b0;
            else                v[i] = 1'b1;
        end
        return v;
    endfunction

    assign bus.sclk    = sclk_reg;
    assign bus.mosi    = mosi_reg;
    assign bus.cs_n    = cs_n_reg;
    assign bus.rd_data = rd_data_reg;

    // FIFO flags, engine events, CPU access decode and read-data mux
    always_comb begin
        tx_full    = (tx_cnt == CNT_FULL);
        tx_empty   = (tx_cnt == '0);
        rx_full    = (rx_cnt == CNT_FULL);
        rx_empty   = (rx_cnt == '0);
        busy       = (state != IDLE);
        h_done     = (cnt == div_l);
        last_half  = (half == HALF_LAST);
        tx_pop     = 1'b0;
        rx_push_ev = 1'b0;
        edge_now   = 1'b0;
        edge_lead  = 1'b0;
        case (state)
            IDLE:  tx_pop = ctl_en && !tx_empty;
            LEAD:  begin edge_now = h_done; edge_lead = 1'b1; end
            SHIFT: begin
                if (h_done && last_half) begin
                    rx_push_ev = 1'b1;
                    tx_pop     = ctl_en && !tx_empty;
                end else begin
                    edge_now  = h_done;
                    edge_lead = half[0];
                end
            end
            TRAIL: begin edge_now = h_done && chain; edge_lead = 1'b1; end
            default: begin edge_now = 1'b0; edge_lead = 1'b0; end
        endcase
        // CPHA=0 samples on leading edges, CPHA=1 on trailing edges
        do_sample  = edge_lead ^ cpha_l;
        load_cpha  = (state == IDLE) ? ctl_cpha : cpha_l;
        frame      = tx_mem[tx_rp];
        tx_push    = bus.wr_en && (bus.addr == A_TX) && (!tx_full || tx_pop);
        tx_ovf_set = bus.wr_en && (bus.addr == A_TX) && tx_full && !tx_pop;
        rx_pop     = bus.rd_en && (bus.addr == A_RX) && !rx_empty;
        rx_push    = rx_push_ev && (!rx_full || rx_pop);
        rx_ovf_set = rx_push_ev && rx_full && !rx_pop;
        stat_rd    = bus.rd_en && (bus.addr == A_STATUS);
        rd_mux     = '0;
        case (bus.addr)
            A_CTRL: begin
                rd_mux[0]            = ctl_en;
                rd_mux[1]            = ctl_cpha;
                rd_mux[2]            = ctl_cpol;
                rd_mux[8 +: W_DIV]   = ctl_div;
                rd_mux[16 +: CS_W]   = ctl_cs;
            end
            A_STATUS: rd_mux[6:0] = {tx_ovf, rx_ovf, rx_empty, rx_full, tx_empty, tx_full, busy};
            A_RX: begin
                if (!rx_empty) rd_mux[W_FRAME-1:0] = rx_mem[rx_rp];
                else           rd_mux = '0;
            end
            default: rd_mux = '0;
        endcase
    end

    // CTRL register, sticky overflow flags and registered read data
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctl_en      <= 1'b0;
            ctl_cpha    <= 1'b0;
            ctl_cpol    <= 1'b0;
            ctl_div     <= '0;
            ctl_cs      <= '0;
            tx_ovf      <= 1'b0;
            rx_ovf      <= 1'b0;
            rd_data_reg <= '0;
        end else begin
            if (bus.wr_en && (bus.addr == A_CTRL)) begin
                ctl_en   <= bus.wd[0];
                ctl_cpha <= bus.wd[1];
                ctl_cpol <= bus.wd[2];
                ctl_div  <= bus.wd[8 +: W_DIV];
                ctl_cs   <= bus.wd[16 +: CS_W];
            end
            if (bus.rd_en) rd_data_reg <= rd_mux;
            // a new overflow in the same cycle as a STATUS read stays visible
            if (tx_ovf_set)   tx_ovf <= 1'b1;
            else if (stat_rd) tx_ovf <= 1'b0;
            if (rx_ovf_set)   rx_ovf <= 1'b1;
            else if (stat_rd) rx_ovf <= 1'b0;
        end
    end

    // FIFO pointers and occupancy counts
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_wp <= '0; tx_rp <= '0; tx_cnt <= '0;
            rx_wp <= '0; rx_rp <= '0; rx_cnt <= '0;
        end else begin
            if (tx_push) tx_wp <= tx_wp + AW'(1);
            if (tx_pop)  tx_rp <= tx_rp + AW'(1);
            if (tx_push && !tx_pop)      tx_cnt <= tx_cnt + (AW + 1)'(1);
            else if (!tx_push && tx_pop) tx_cnt <= tx_cnt - (AW + 1)'(1);
            if (rx_push) rx_wp <= rx_wp + AW'(1);
            if (rx_pop)  rx_rp <= rx_rp + AW'(1);
            if (rx_push && !rx_pop)      rx_cnt <= rx_cnt + (AW + 1)'(1);
            else if (!rx_push && rx_pop) rx_cnt <= rx_cnt - (AW + 1)'(1);
        end
    end

    // FIFO storage (contents are qualified by the counts, so no reset)
    always_ff @(posedge clk) begin
        if (tx_push) tx_mem[tx_wp] <= bus.wd[W_FRAME-1:0];
        if (rx_push) rx_mem[rx_wp] <= rx_sr;
    end

    // transfer engine: state sequencing, sclk/mosi/cs_n generation, miso capture
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            cpha_l   <= 1'b0;
            cpol_l   <= 1'b0;
            div_l    <= '0;
            cnt      <= '0;
            half     <= '0;
            chain    <= 1'b0;
            tx_sr    <= '0;
            rx_sr    <= '0;
            sclk_reg <= 1'b0;
            mosi_reg <= 1'b0;
            cs_n_reg <= '1;
        end else begin
            case (state)
                IDLE: begin
                    sclk_reg <= ctl_cpol;
                    cs_n_reg <= '1;
                    cnt      <= '0;
                    if (tx_pop) begin
                        state    <= LEAD;
                        cpha_l   <= ctl_cpha;
                        cpol_l   <= ctl_cpol;
                        div_l    <= ctl_div;
                        cs_n_reg <= cs_decode(ctl_cs);
                    end
                end
                LEAD: begin
                    if (h_done) begin
                        state <= SHIFT;
                        cnt   <= '0;
                        half  <= '0;
                    end else begin
                        cnt <= cnt + W_DIV'(1);
                    end
                end
                SHIFT: begin
                    if (h_done) begin
                        cnt <= '0;
                        if (last_half) begin
                            state <= TRAIL;
                            chain <= tx_pop;
                        end else begin
                            half <= half + HW'(1);
                        end
                    end else begin
                        cnt <= cnt + W_DIV'(1);
                    end
                end
                TRAIL: begin
                    if (h_done) begin
                        cnt  <= '0;
                        half <= '0;
                        if (chain) begin
                            state <= SHIFT;
                        end else begin
                            state    <= IDLE;
                            cs_n_reg <= '1;
                        end
                    end else begin
                        cnt <= cnt + W_DIV'(1);
                    end
                end
                default: state <= IDLE;
            endcase
            // the next frame is loaded a full phase before its first sclk edge,
            // so with CPHA=0 the MSB is already stable on mosi
            if (tx_pop) begin
                if (load_cpha) begin
                    tx_sr <= frame;
                end else begin
                    mosi_reg <= frame[W_FRAME-1];
                    tx_sr    <= frame << 1;
                end
            end
            if (edge_now) begin
                sclk_reg <= cpol_l ^ edge_lead;
                if (do_sample) begin
                    rx_sr <= {rx_sr[W_FRAME-2:0], bus.miso};
                end else begin
                    mosi_reg <= tx_sr[W_FRAME-1];
                    tx_sr    <= tx_sr << 1;
                end
            end
        end
    end
endmodule

// File: tb/tb_spi_master_ctrl.sv
// Directed bench for spi_master_ctrl: register vector table followed by
// hand-written transfer sequences, with an SPI pin monitor in tick().
module tb_spi_master_ctrl;
    localparam int W_CPU = 32, W_FRAME = 8, N_CS = 4, FIFO_DEPTH = 4, W_DIV = 8;
    localparam logic [1:0] A_CTRL = 2'd0, A_STATUS = 2'd1, A_TX = 2'd2, A_RX = 2'd3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic loop_en = 1'b0;
    logic miso_val = 1'b0;

    always #5 clk = ~clk;

    spi_master_ctrl_if #(.W_CPU(W_CPU), .N_CS(N_CS)) ifc ();
    assign ifc.miso = loop_en ? ifc.mosi : miso_val;

    spi_master_ctrl #(.W_CPU(W_CPU), .W_FRAME(W_FRAME), .N_CS(N_CS),
                      .FIFO_DEPTH(FIFO_DEPTH), .W_DIV(W_DIV))
        dut (.clk(clk), .rst(rst), .bus(ifc.slave));

    typedef struct {
        logic        wr;
        logic [1:0]  addr;
        logic [31:0] wd;
        logic [31:0] exp;
    } vec_t;

    int errors = 0;
    int checks = 0;

    // pin monitor state, refreshed by tick()
    int              cyc, low_cnt, low_runs, cs_bad, lead_n, last_lead, per_bad, mon_period;
    logic            mon_cpol, mon_cpha, prev_sclk;
    logic [N_CS-1:0] mon_cs, prev_cs;
    logic [31:0]     mon_bits;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic mon_clear(input logic cpol, input logic cpha, input logic [N_CS-1:0] cs, input int period);
        cyc = 0; low_cnt = 0; low_runs = 0; cs_bad = 0; lead_n = 0; last_lead = 0; per_bad = 0;
        mon_cpol = cpol; mon_cpha = cpha; mon_cs = cs; mon_period = period;
        mon_bits = 32'h0; prev_sclk = ifc.sclk; prev_cs = ifc.cs_n;
    endtask

    task automatic tick();
        logic lead;
        @(posedge clk);
        #1;
        cyc++;
        if (ifc.cs_n !== {N_CS{1'b1}}) begin
            low_cnt++;
            if (prev_cs === {N_CS{1'b1}}) low_runs++;
            if (ifc.cs_n !== mon_cs) cs_bad++;
        end
        if (ifc.sclk !== prev_sclk) begin
            lead = (prev_sclk === mon_cpol);
            if (lead) begin
                if (lead_n > 0 && mon_period != 0 && (cyc - last_lead) != mon_period) per_bad++;
                lead_n++;
                last_lead = cyc;
            end
            if (lead != mon_cpha) mon_bits = {mon_bits[30:0], ifc.mosi};
        end
        prev_sclk = ifc.sclk;
        prev_cs   = ifc.cs_n;
    endtask

    task automatic cpu_write(input logic [1:0] a, input logic [31:0] d);
        ifc.wr_en = 1'b1; ifc.addr = a; ifc.wd = d;
        tick();
        ifc.wr_en = 1'b0; ifc.wd = 32'h0;
    endtask

    task automatic cpu_read(input logic [1:0] a, output logic [31:0] d);
        ifc.rd_en = 1'b1; ifc.addr = a;
        tick();
        ifc.rd_en = 1'b0;
        d = ifc.rd_data;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // wait until the current chip-select run has ended, bounded
    task automatic wait_frame_end(input string name, input int budget);
        for (int c = 0; c < budget; c++) begin
            if (low_runs > 0 && ifc.cs_n === {N_CS{1'b1}}) break;
            tick();
        end
        check(name, 32'(ifc.cs_n), 32'hF);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach the summary");
        $fatal(1);
    end

    initial begin
        vec_t        vecs [19];
        logic [31:0] d;
        logic [31:0] ctrl;
        logic [31:0] rx_exp [4];

        vecs[0]  = '{1'b0, A_STATUS, 32'h0,         32'h14};
        vecs[1]  = '{1'b1, A_CTRL,   32'hF0F3_AB06, 32'h0};
        vecs[2]  = '{1'b0, A_CTRL,   32'h0,         32'h0003_AB06};
        vecs[3]  = '{1'b0, A_TX,     32'h0,         32'h0};
        vecs[4]  = '{1'b0, A_RX,     32'h0,         32'h0};
        vecs[5]  = '{1'b1, A_STATUS, 32'hFFFF_FFFF, 32'h0};
        vecs[6]  = '{1'b1, A_RX,     32'hFFFF_FFFF, 32'h0};
        vecs[7]  = '{1'b0, A_STATUS, 32'h0,         32'h14};
        vecs[8]  = '{1'b1, A_CTRL,   32'h0,         32'h0};
        vecs[9]  = '{1'b0, A_CTRL,   32'h0,         32'h0};
        vecs[10] = '{1'b1, A_TX,     32'h11,        32'h0};
        vecs[11] = '{1'b1, A_TX,     32'hFFFF_FF22, 32'h0};
        vecs[12] = '{1'b1, A_TX,     32'h33,        32'h0};
        vecs[13] = '{1'b1, A_TX,     32'h44,        32'h0};
        vecs[14] = '{1'b0, A_STATUS, 32'h0,         32'h12};
        vecs[15] = '{1'b1, A_TX,     32'h55,        32'h0};
        vecs[16] = '{1'b1, A_TX,     32'h66,        32'h0};
        vecs[17] = '{1'b0, A_STATUS, 32'h0,         32'h52};
        vecs[18] = '{1'b0, A_STATUS, 32'h0,         32'h12};
        rx_exp = '{32'h11, 32'h22, 32'h33, 32'h44};

        ifc.wr_en = 1'b0; ifc.rd_en = 1'b0; ifc.addr = 2'd0; ifc.wd = 32'h0;
        mon_clear(1'b0, 1'b0, 4'hF, 0);

        // reset state while rst is held
        tick();
        tick();
        check("rst_rd_data", ifc.rd_data, 32'h0);
        check("rst_sclk", 32'(ifc.sclk), 32'h0);
        check("rst_mosi", 32'(ifc.mosi), 32'h0);
        check("rst_cs_n", 32'(ifc.cs_n), 32'hF);
        rst = 1'b0;
        tick();

        // register map and TX overflow (engine disabled)
        for (int i = 0; i < 19; i++) begin
            if (vecs[i].wr) begin
                cpu_write(vecs[i].addr, vecs[i].wd);
            end else begin
                cpu_read(vecs[i].addr, d);
                check($sformatf("vec%0d", i), d, vecs[i].exp);
            end
        end

        // drain the four queued frames, then overflow RX with a fifth
        loop_en = 1'b1;
        cpu_write(A_CTRL, 32'h0000_0001);
        repeat (100) tick();
        cpu_read(A_STATUS, d);
        check("rx_full_status", d, 32'h0C);
        cpu_write(A_TX, 32'h55);
        repeat (40) tick();
        cpu_read(A_STATUS, d);
        check("rx_ovf_status", d, 32'h2C);
        for (int i = 0; i < 4; i++) begin
            cpu_read(A_RX, d);
            check($sformatf("rx_hold%0d", i), d, rx_exp[i]);
        end
        cpu_read(A_STATUS, d);
        check("rx_drained_status", d, 32'h14);
        cpu_read(A_RX, d);
        check("rx_empty_read", d, 32'h0);

        // mode 0, div 0, cs_sel 1, 0xA5 looped back
        do_reset();
        cpu_write(A_CTRL, 32'h0001_0001);
        mon_clear(1'b0, 1'b0, 4'hD, 2);
        cpu_write(A_TX, 32'hA5);
        check("m0_cs_before_lead", 32'(ifc.cs_n), 32'hF);
        tick();
        check("m0_cs_at_lead", 32'(ifc.cs_n), 32'hD);
        wait_frame_end("m0_done", 200);
        check("m0_cs_low_cycles", low_cnt, 18);
        check("m0_cs_runs", low_runs, 1);
        check("m0_cs_value", cs_bad, 0);
        check("m0_lead_edges", lead_n, 8);
        check("m0_period", per_bad, 0);
        check("m0_mosi_bits", mon_bits, 32'hA5);
        cpu_read(A_RX, d);
        check("m0_rx", d, 32'hA5);
        cpu_read(A_STATUS, d);
        check("m0_status", d, 32'h14);

        // modes 1..3, div 3, miso tied high
        loop_en  = 1'b0;
        miso_val = 1'b1;
        for (int m = 1; m <= 3; m++) begin
            do_reset();
            ctrl    = 32'h0000_0301;
            ctrl[1] = m[0];
            ctrl[2] = m[1];
            cpu_write(A_CTRL, ctrl);
            tick();
            check($sformatf("mode%0d_sclk_idle", m), 32'(ifc.sclk), 32'(m[1]));
            mon_clear(m[1], m[0], 4'hE, 8);
            cpu_write(A_TX, 32'h3C);
            wait_frame_end($sformatf("mode%0d_done", m), 400);
            check($sformatf("mode%0d_cs_low_cycles", m), low_cnt, 72);
            check($sformatf("mode%0d_lead_edges", m), lead_n, 8);
            check($sformatf("mode%0d_period", m), per_bad, 0);
            check($sformatf("mode%0d_mosi_bits", m), mon_bits, 32'h3C);
            check($sformatf("mode%0d_sclk_after", m), 32'(ifc.sclk), 32'(m[1]));
            cpu_read(A_RX, d);
            check($sformatf("mode%0d_rx", m), d, 32'hFF);
        end

        // three back-to-back frames on cs_sel 2
        do_reset();
        loop_en = 1'b1;
        cpu_write(A_CTRL, 32'h0002_0001);
        mon_clear(1'b0, 1'b0, 4'hB, 0);
        cpu_write(A_TX, 32'h81);
        cpu_write(A_TX, 32'h7E);
        cpu_write(A_TX, 32'hC3);
        wait_frame_end("b2b_done", 300);
        check("b2b_cs_low_cycles", low_cnt, 52);
        check("b2b_cs_runs", low_runs, 1);
        check("b2b_cs_value", cs_bad, 0);
        check("b2b_mosi_bits", mon_bits, 32'h0081_7EC3);
        cpu_read(A_RX, d);
        check("b2b_rx0", d, 32'h81);
        cpu_read(A_RX, d);
        check("b2b_rx1", d, 32'h7E);
        cpu_read(A_RX, d);
        check("b2b_rx2", d, 32'hC3);

        // asynchronous reset in the middle of SHIFT (CPOL=1, cs_sel 3)
        do_reset();
        cpu_write(A_CTRL, 32'h0003_0305);
        cpu_read(A_CTRL, d);
        check("ar_ctrl_readback", d, 32'h0003_0305);
        cpu_write(A_TX, 32'h5A);
        repeat (20) tick();
        check("ar_cs_mid_frame", 32'(ifc.cs_n), 32'h7);
        #3;
        rst = 1'b1;
        #1;
        check("ar_cs_n", 32'(ifc.cs_n), 32'hF);
        check("ar_sclk", 32'(ifc.sclk), 32'h0);
        check("ar_rd_data", ifc.rd_data, 32'h0);
        tick();
        rst = 1'b0;
        cpu_read(A_STATUS, d);
        check("ar_status", d, 32'h14);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
